hyperbus_trx_seq: RTL and testbench
===================================

// Module: hyperbus_trx_seq
// PURPOSE
// Transaction sequencer driving the control side of the HyperBus transceiver.
// Accepts one burst request at a time and runs the bus phases in order: CS setup, 48-bit command/address (CA), latency, write or read data, CS hold, recovery.
// Steers chip select, output enables, CK gating, RWDS sampling and RX clock set/reset, and forwards write/read words to and from the system side.
// PARAMETERS
// NumChips      2    number of chip selects (one-hot trans_cs_i)
// TimeoutCycles 1024 max clk_i cycles without a read word before read abort
// PORTS
// clk_i              in  1        PHY clock; single clock domain
// rst_ni             in  1        async reset, active low
// trans_valid_i      in  1        request valid
// trans_ready_o      out 1        request accepted (high only in IDLE)
// trans_write_i      in  1        1=write, 0=read
// trans_reg_i        in  1        1=register space, 0=memory
// trans_addr_i       in  32       16-bit-word address
// trans_burst_i      in  16       burst length in 16-bit words; 0 treated as 1
// trans_cs_i         in  NumChips one-hot chip select
// cfg_latency_i      in  4        initial latency in clk_i cycles; values <3 clamped to 3
// cfg_fixed_lat_i    in  1        1=always double latency
// cfg_t_rwr_i        in  4        recovery cycles with CS high between transactions
// tx_valid_i/tx_ready_o  in/out 1 write-word handshake
// tx_data_i          in  16       write word; tx_strb_i in 2 byte enables (1=write)
// rx_data_o          out 16       read word; rx_valid_o out 1 / rx_ready_i in 1 handshake
// trans_done_o       out 1        1-cycle pulse at end of CS_HOLD; trans_error_o out 1 valid with it
// trx_cs_o NumChips, trx_cs_ena_o, trx_tx_clk_ena_o, trx_tx_data_o 16, trx_tx_data_oe_o, trx_tx_rwds_o 2, trx_tx_rwds_oe_o, trx_rwds_sample_ena_o, trx_rx_clk_set_o, trx_rx_clk_reset_o   out  (to transceiver)
// trx_rwds_sample_i in 1, trx_rx_data_i in 16, trx_rx_valid_i in 1, trx_rx_ready_o out 1  (from transceiver)
// BEHAVIOUR
// - Reset: all outputs 0 except trans_ready_o=1 (IDLE); counters 0; state IDLE. Reset mid-transaction aborts at once: CS released, no done pulse.
// - States: IDLE -> CS_SETUP(1) -> CA(3) -> LAT_WAIT -> WRITE|READ -> CS_HOLD(1) -> RECOVER(cfg_t_rwr_i, 0 = skip) -> IDLE.
// - IDLE: on trans_valid_i&trans_ready_o, register request, trx_cs_o=trans_cs_i, cs_ena=1.
// - CA words, MSB first: CA[47]=~write, [46]=reg, [45]=1 (linear), [44:16]=addr[31:3], [15:3]=0, [2:0]=addr[2:0]. data_oe=1, clk_ena=1, rwds_sample_ena=1.
// - Register write: CA -> WRITE directly, zero latency, rwds_oe=0.
// - LAT_WAIT: length L=max(cfg_latency_i,3) minus 1. At LAT_WAIT cycle 1, latch double = cfg_fixed_lat_i | trx_rwds_sample_i; if set, add L cycles. Read: rx_clk_set pulse in last LAT_WAIT cycle.
// - WRITE: tx_ready_o=1 when word counter < burst. Word sent when tx_valid_i: data_oe=1, rwds_oe=1, trx_tx_rwds_o=~tx_strb_i. If tx_valid_i=0: clk_ena=0 (CK stopped), counter holds. Last word -> CS_HOLD.
// - READ: trx_rx_ready_o=rx_ready_i; rx_* pass-through (0 latency). CK stopped while rx_ready_i=0. Counter increments per rx handshake. Last word -> rx_clk_reset pulse, CS_HOLD.
// - Timeout: counter resets on each rx word; reaching TimeoutCycles -> rx_clk_reset, CS_HOLD, trans_error_o=1.
// - CS_HOLD: clk_ena=0, cs still asserted (tCSH), then cs_ena=0, trans_done_o pulse.
// - Counters 16-bit, no wrap: burst 0xFFFF completes exactly 65535 words.
// - A new request while busy is held (ready=0), never dropped.
// STRUCTURE
// - Package hyperbus_seq_pkg: state_e enum, ca_t packed struct (48 b), CA field constants.
// - Sub-module hyperbus_seq_ca_pack: request -> ca_t (combinational); the rest is a single FSM plus word, latency, timeout and recovery counters.
// TESTING
// - Mem read, addr 0x0000_1234, burst 4, lat 6, rwds_sample=0 -> CA 0xA000_0246_0004; 5 LAT_WAIT cycles; 4 rx words out; done, error=0.
// - Same read with rwds_sample=1 at LAT_WAIT cycle 1 -> LAT_WAIT lasts 10 cycles; with cfg_fixed_lat_i=1 -> 10 cycles regardless of rwds_sample.
// - Reg write, addr 0x800, data 0x8F1F -> CA[47:45]=3'b011; data word follows CA with no latency; rwds_oe=0.
// - Mem write, burst 3, tx_valid low 2 cycles mid-burst -> clk_ena=0 for those 2 cycles; exactly 3 words; strb 2'b01 -> rwds 2'b10.
// - Read with trx_rx_valid_i stuck 0, TimeoutCycles=16 -> after 16 cycles rx_clk_reset=1; done with error=1; next request accepted after recovery.
// - rst_ni low during READ -> cs_ena=0, trans_ready_o=1 immediately; no done pulse.

Source files
------------

// File: rtl/hyperbus_seq_pkg.sv
// Shared types for the HyperBus transaction sequencer: FSM states and the 48-bit
// command/address word layout.
package hyperbus_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StCa,
        StLatWait,
        StWrite,
        StRead,
        StCsHold,
        StRecover
    } state_e;

    // Field order is MSB first, matching the order the CA words go out on the bus.
    typedef struct packed {
        logic        rw_n;      // 1 = read
        logic        as_reg;    // 1 = register space
        logic        linear;    // burst type
        logic [28:0] addr_hi;   // addr[31:3]
        logic [12:0] rsvd;
        logic [2:0]  addr_lo;   // addr[2:0]
    } ca_t;

    localparam logic        CaBurstLinear = 1'b1;
    localparam int unsigned CaWords       = 3;
    localparam int unsigned MinLatency    = 3;

endpackage

// File: rtl/hyperbus_trx_seq_if.sv
// Control bundle between the transaction sequencer (master) and the HyperBus
// transceiver (slave).
interface hyperbus_trx_seq_if #(
    parameter int unsigned NumChips = 2
);
    logic [NumChips-1:0] cs;
    logic                cs_ena;
    logic                tx_clk_ena;
    logic [15:0]         tx_data;
    logic                tx_data_oe;
    logic [1:0]          tx_rwds;
    logic                tx_rwds_oe;
    logic                rwds_sample_ena;
    logic                rx_clk_set;
    logic                rx_clk_reset;
    logic                rwds_sample;
    logic [15:0]         rx_data;
    logic                rx_valid;
    logic                rx_ready;

    modport master (
        output cs, cs_ena, tx_clk_ena, tx_data, tx_data_oe, tx_rwds, tx_rwds_oe,
               rwds_sample_ena, rx_clk_set, rx_clk_reset, rx_ready,
        input  rwds_sample, rx_data, rx_valid
    );

    modport slave (
        input  cs, cs_ena, tx_clk_ena, tx_data, tx_data_oe, tx_rwds, tx_rwds_oe,
               rwds_sample_ena, rx_clk_set, rx_clk_reset, rx_ready,
        output rwds_sample, rx_data, rx_valid
    );
endinterface

// File: rtl/hyperbus_seq_ca_pack.sv
// Packs a registered burst request into the 48-bit HyperBus command/address word.
module hyperbus_seq_ca_pack
    import hyperbus_seq_pkg::*;
(
    input  logic        write_i,
    input  logic        reg_i,
    input  logic [31:0] addr_i,
    output ca_t         ca_o
);

    always_comb begin
        ca_o         = '0;
        ca_o.rw_n    = ~write_i;
        ca_o.as_reg  = reg_i;
        ca_o.linear  = CaBurstLinear;
        ca_o.addr_hi = addr_i[31:3];
        ca_o.rsvd    = '0;
        ca_o.addr_lo = addr_i[2:0];
    end

endmodule

// File: rtl/hyperbus_trx_seq.sv
// HyperBus transaction sequencer: runs CS setup, CA, latency, data, CS hold and
// recovery phases for one burst at a time and steers the transceiver controls.
module hyperbus_trx_seq
    import hyperbus_seq_pkg::*;
#(
    parameter int unsigned NumChips      = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                trans_valid_i,
    output logic                trans_ready_o,
    input  logic                trans_write_i,
    input  logic                trans_reg_i,
    input  logic [31:0]         trans_addr_i,
    input  logic [15:0]         trans_burst_i,
    input  logic [NumChips-1:0] trans_cs_i,
    input  logic [3:0]          cfg_latency_i,
    input  logic                cfg_fixed_lat_i,
    input  logic [3:0]          cfg_t_rwr_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    input  logic [15:0]         tx_data_i,
    input  logic [1:0]          tx_strb_i,
    output logic [15:0]         rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic                trans_done_o,
    output logic                trans_error_o,
    hyperbus_trx_seq_if.master  trx
);

    localparam int unsigned ToW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    state_e              state_q;
    logic [NumChips-1:0] cs_q;
    logic                cs_ena_q;
    logic                write_q, reg_q;
    logic [31:0]         addr_q;
    logic [15:0]         burst_q;
    logic [3:0]          lat_q;
    logic [1:0]          ca_cnt_q;
    logic [4:0]          lat_cnt_q;
    logic                dbl_q;
    logic [15:0]         word_cnt_q;
    logic [ToW-1:0]      to_cnt_q;
    logic [3:0]          rec_cnt_q;
    logic                abort_q;
    logic                done_q, error_q;

    ca_t         ca;
    logic [47:0] ca_bits;

    hyperbus_seq_ca_pack u_ca_pack (
        .write_i (write_q),
        .reg_i   (reg_q),
        .addr_i  (addr_q),
        .ca_o    (ca)
    );
    assign ca_bits = ca;

    // Latency doubling is decided from RWDS in the first LAT_WAIT cycle, so that cycle
    // looks at the live input and later cycles use the latched decision.
    logic       lat_dbl, lat_last;
    logic [4:0] lat_total;
    logic       word_last, tx_fire, rx_fire, timeout;

    always_comb begin
        lat_dbl   = (lat_cnt_q == 5'd0) ? (cfg_fixed_lat_i | trx.rwds_sample) : dbl_q;
        lat_total = lat_dbl ? {lat_q, 1'b0} : {1'b0, lat_q};
        lat_last  = (lat_cnt_q == lat_total - 5'd1);
        word_last = (word_cnt_q == burst_q - 16'd1);
        tx_fire   = (state_q == StWrite) && tx_valid_i;
        rx_fire   = (state_q == StRead) && trx.rx_valid && rx_ready_i;
        timeout   = (state_q == StRead) && !rx_fire && (to_cnt_q == ToW'(TimeoutCycles - 1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cs_q       <= '0;
            cs_ena_q   <= 1'b0;
            write_q    <= 1'b0;
            reg_q      <= 1'b0;
            addr_q     <= '0;
            burst_q    <= '0;
            lat_q      <= '0;
            ca_cnt_q   <= '0;
            lat_cnt_q  <= '0;
            dbl_q      <= 1'b0;
            word_cnt_q <= '0;
            to_cnt_q   <= '0;
            rec_cnt_q  <= '0;
            abort_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (trans_valid_i) begin
                        write_q  <= trans_write_i;
                        reg_q    <= trans_reg_i;
                        addr_q   <= trans_addr_i;
                        burst_q  <= (trans_burst_i == 16'd0) ? 16'd1 : trans_burst_i;
                        lat_q    <= (cfg_latency_i < 4'(MinLatency)) ? 4'(MinLatency - 1)
                                                                     : cfg_latency_i - 4'd1;
                        cs_q     <= trans_cs_i;
                        cs_ena_q <= 1'b1;
                        abort_q  <= 1'b0;
                        state_q  <= StCsSetup;
                    end
                end
                StCsSetup: begin
                    ca_cnt_q <= '0;
                    state_q  <= StCa;
                end
                StCa: begin
                    if (ca_cnt_q == 2'(CaWords - 1)) begin
                        lat_cnt_q  <= '0;
                        word_cnt_q <= '0;
                        state_q    <= (write_q && reg_q) ? StWrite : StLatWait;
                    end else begin
                        ca_cnt_q <= ca_cnt_q + 2'd1;
                    end
                end
                StLatWait: begin
                    if (lat_cnt_q == 5'd0) dbl_q <= lat_dbl;
                    if (lat_last) begin
                        to_cnt_q <= '0;
                        state_q  <= write_q ? StWrite : StRead;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 5'd1;
                    end
                end
                StWrite: begin
                    if (tx_fire) begin
                        if (word_last) state_q <= StCsHold;
                        else           word_cnt_q <= word_cnt_q + 16'd1;
                    end
                end
                StRead: begin
                    if (rx_fire) begin
                        to_cnt_q <= '0;
                        if (word_last) state_q <= StCsHold;
                        else           word_cnt_q <= word_cnt_q + 16'd1;
                    end else if (timeout) begin
                        abort_q <= 1'b1;
                        state_q <= StCsHold;
                    end else begin
                        to_cnt_q <= to_cnt_q + ToW'(1);
                    end
                end
                StCsHold: begin
                    cs_ena_q  <= 1'b0;
                    cs_q      <= '0;
                    done_q    <= 1'b1;
                    error_q   <= abort_q;
                    abort_q   <= 1'b0;
                    rec_cnt_q <= '0;
                    state_q   <= (cfg_t_rwr_i == 4'd0) ? StIdle : StRecover;
                end
                StRecover: begin
                    if (({1'b0, rec_cnt_q} + 5'd1) >= {1'b0, cfg_t_rwr_i}) state_q <= StIdle;
                    else rec_cnt_q <= rec_cnt_q + 4'd1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic        clk_ena, data_oe, rwds_oe, sample_ena, rx_set, rx_reset, rx_rdy;
    logic [15:0] tx_data;
    logic [1:0]  tx_rwds;

    // Data-phase controls follow the handshakes in the same cycle so CK stops exactly
    // on the cycles where no word moves.
    always_comb begin
        clk_ena    = 1'b0;
        data_oe    = 1'b0;
        rwds_oe    = 1'b0;
        sample_ena = 1'b0;
        rx_set     = 1'b0;
        rx_reset   = 1'b0;
        rx_rdy     = 1'b0;
        tx_data    = '0;
        tx_rwds    = '0;
        rx_valid_o = 1'b0;
        rx_data_o  = '0;
        unique case (state_q)
            StCa: begin
                clk_ena    = 1'b1;
                data_oe    = 1'b1;
                sample_ena = 1'b1;
                case (ca_cnt_q)
                    2'd0:    tx_data = ca_bits[47:32];
                    2'd1:    tx_data = ca_bits[31:16];
                    default: tx_data = ca_bits[15:0];
                endcase
            end
            StLatWait: begin
                clk_ena = 1'b1;
                rx_set  = !write_q && lat_last;
            end
            StWrite: begin
                if (tx_valid_i) begin
                    clk_ena = 1'b1;
                    data_oe = 1'b1;
                    tx_data = tx_data_i;
                    rwds_oe = !reg_q;
                    tx_rwds = reg_q ? 2'b00 : ~tx_strb_i;
                end
            end
            StRead: begin
                clk_ena    = rx_ready_i;
                rx_rdy     = rx_ready_i;
                rx_valid_o = trx.rx_valid;
                rx_data_o  = trx.rx_data;
                rx_reset   = (rx_fire && word_last) || timeout;
            end
            default: ;
        endcase
    end

    assign trans_ready_o       = (state_q == StIdle);
    assign tx_ready_o          = (state_q == StWrite) && (word_cnt_q < burst_q);
    assign trans_done_o        = done_q;
    assign trans_error_o       = error_q;
    assign trx.cs              = cs_q;
    assign trx.cs_ena          = cs_ena_q;
    assign trx.tx_clk_ena      = clk_ena;
    assign trx.tx_data         = tx_data;
    assign trx.tx_data_oe      = data_oe;
    assign trx.tx_rwds         = tx_rwds;
    assign trx.tx_rwds_oe      = rwds_oe;
    assign trx.rwds_sample_ena = sample_ena;
    assign trx.rx_clk_set      = rx_set;
    assign trx.rx_clk_reset    = rx_reset;
    assign trx.rx_ready        = rx_rdy;

endmodule

// File: tb/tb_hyperbus_trx_seq.sv
// Directed bench for hyperbus_trx_seq: reads, latency doubling, register and memory
// writes, read timeout, held requests and mid-transaction reset.
module tb_hyperbus_trx_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        trans_valid_i = 1'b0, trans_ready_o;
    logic        trans_write_i = 1'b0, trans_reg_i = 1'b0;
    logic [31:0] trans_addr_i = '0;
    logic [15:0] trans_burst_i = '0;
    logic [1:0]  trans_cs_i = '0;
    logic [3:0]  cfg_latency_i = 4'd6;
    logic        cfg_fixed_lat_i = 1'b0;
    logic [3:0]  cfg_t_rwr_i = 4'd2;
    logic        tx_valid_i = 1'b0, tx_ready_o;
    logic [15:0] tx_data_i = '0;
    logic [1:0]  tx_strb_i = '0;
    logic [15:0] rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b1;
    logic        trans_done_o, trans_error_o;

    int vecs = 0;
    int errs = 0;

    hyperbus_trx_seq_if #(.NumChips(2)) trx_if ();

    hyperbus_trx_seq #(.NumChips(2), .TimeoutCycles(16)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .trans_valid_i   (trans_valid_i),
        .trans_ready_o   (trans_ready_o),
        .trans_write_i   (trans_write_i),
        .trans_reg_i     (trans_reg_i),
        .trans_addr_i    (trans_addr_i),
        .trans_burst_i   (trans_burst_i),
        .trans_cs_i      (trans_cs_i),
        .cfg_latency_i   (cfg_latency_i),
        .cfg_fixed_lat_i (cfg_fixed_lat_i),
        .cfg_t_rwr_i     (cfg_t_rwr_i),
        .tx_valid_i      (tx_valid_i),
        .tx_ready_o      (tx_ready_o),
        .tx_data_i       (tx_data_i),
        .tx_strb_i       (tx_strb_i),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (rx_ready_i),
        .trans_done_o    (trans_done_o),
        .trans_error_o   (trans_error_o),
        .trx             (trx_if)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        trx_if.rwds_sample = 1'b0;
        trx_if.rx_data     = '0;
        trx_if.rx_valid    = 1'b0;
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    // Presents one request in IDLE; returns in the CS_SETUP cycle.
    task automatic send_req(input logic wr, input logic rg, input logic [31:0] addr,
                            input logic [15:0] burst, input logic [1:0] cs);
        trans_valid_i = 1'b1;
        trans_write_i = wr;
        trans_reg_i   = rg;
        trans_addr_i  = addr;
        trans_burst_i = burst;
        trans_cs_i    = cs;
        step();
        trans_valid_i = 1'b0;
    endtask

    // CS_SETUP -> through the three CA cycles -> first LAT_WAIT cycle.
    task automatic to_latency();
        repeat (4) step();
    endtask

    // From LAT_WAIT cycle 1: counts cycles up to the rx_clk_set pulse, ends in READ.
    task automatic count_read_latency(input logic rwds1, output int n);
        trx_if.rwds_sample = rwds1;
        #1;
        n = 1;
        while (!trx_if.rx_clk_set && n < 40) begin
            step();
            trx_if.rwds_sample = 1'b0;
            #1;
            n++;
        end
        trx_if.rwds_sample = 1'b0;
        step();
    endtask

    // From the CS_HOLD cycle: records hold, done/error pulse, and recovery length.
    task automatic close_txn(output logic hold_ok, output logic done, output logic err,
                             output logic released, output int rec);
        #1;
        hold_ok = trx_if.cs_ena && !trx_if.tx_clk_ena && !trans_done_o;
        step();
        #1;
        done     = trans_done_o;
        err      = trans_error_o;
        released = !trx_if.cs_ena;
        rec = 0;
        while (!trans_ready_o && rec < 20) begin
            step();
            #1;
            rec++;
        end
    endtask

    task automatic test_reset();
        #1 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #3;
        vecs++; if (trans_ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", trans_ready_o); end
        vecs++; if ({trx_if.cs_ena, trx_if.cs} !== 3'b000) begin errs++; $display("FAIL reset_cs: got %b want 000", {trx_if.cs_ena, trx_if.cs}); end
        vecs++; if ({trx_if.tx_clk_ena, trx_if.tx_data_oe, trx_if.tx_rwds_oe} !== 3'b000) begin errs++; $display("FAIL reset_drv: got %b want 000", {trx_if.tx_clk_ena, trx_if.tx_data_oe, trx_if.tx_rwds_oe}); end
        vecs++; if ({trans_done_o, trans_error_o, tx_ready_o, rx_valid_o} !== 4'b0000) begin errs++; $display("FAIL reset_misc: got %b want 0000", {trans_done_o, trans_error_o, tx_ready_o, rx_valid_o}); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_mem_read();
        logic [15:0] exp_ca [3];
        logic [15:0] wd;
        logic        h, d, e, r;
        int          n;
        exp_ca[0] = 16'hA000; exp_ca[1] = 16'h0246; exp_ca[2] = 16'h0004;
        send_req(1'b0, 1'b0, 32'h0000_1234, 16'd4, 2'b01);
        #1;
        vecs++; if ({trx_if.cs_ena, trx_if.cs, trx_if.tx_clk_ena, trans_ready_o} !== 5'b10100) begin errs++; $display("FAIL rd_cs_setup: got %b want 10100", {trx_if.cs_ena, trx_if.cs, trx_if.tx_clk_ena, trans_ready_o}); end
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            vecs++; if ({trx_if.tx_data_oe, trx_if.tx_clk_ena, trx_if.rwds_sample_ena, trx_if.tx_data} !== {3'b111, exp_ca[i]}) begin errs++; $display("FAIL rd_ca%0d: got %h want %h", i, {trx_if.tx_data_oe, trx_if.tx_clk_ena, trx_if.rwds_sample_ena, trx_if.tx_data}, {3'b111, exp_ca[i]}); end
        end
        step();
        count_read_latency(1'b0, n);
        vecs++; if (n !== 5) begin errs++; $display("FAIL rd_latency: got %0d want 5", n); end
        for (int w = 0; w < 4; w++) begin
            wd = 16'hC000 + 16'(w);
            if (w == 2) begin
                rx_ready_i = 1'b0; trx_if.rx_valid = 1'b1; trx_if.rx_data = wd;
                #1;
                vecs++; if ({trx_if.tx_clk_ena, trx_if.rx_ready} !== 2'b00) begin errs++; $display("FAIL rd_stall_ck: got %b want 00", {trx_if.tx_clk_ena, trx_if.rx_ready}); end
                step();
            end
            rx_ready_i = 1'b1; trx_if.rx_valid = 1'b1; trx_if.rx_data = wd;
            #1;
            vecs++; if ({rx_valid_o, rx_data_o, trx_if.rx_ready, trx_if.rx_clk_reset} !== {1'b1, wd, 1'b1, (w == 3)}) begin errs++; $display("FAIL rd_word%0d: got %h want %h", w, {rx_valid_o, rx_data_o, trx_if.rx_ready, trx_if.rx_clk_reset}, {1'b1, wd, 1'b1, (w == 3)}); end
            step();
        end
        trx_if.rx_valid = 1'b0;
        close_txn(h, d, e, r, n);
        vecs++; if ({h, d, e, r} !== 4'b1101) begin errs++; $display("FAIL rd_close: got %b want 1101", {h, d, e, r}); end
        vecs++; if (n !== 2) begin errs++; $display("FAIL rd_recovery: got %0d want 2", n); end
    endtask

    task automatic test_double_latency();
        logic h, d, e, r;
        int   n;
        send_req(1'b0, 1'b0, 32'h0000_1234, 16'd1, 2'b10);
        to_latency();
        count_read_latency(1'b1, n);
        vecs++; if (n !== 10) begin errs++; $display("FAIL dbl_rwds_latency: got %0d want 10", n); end
        trx_if.rx_valid = 1'b1; trx_if.rx_data = 16'h5A5A;
        #1;
        vecs++; if ({rx_data_o, trx_if.rx_clk_reset} !== {16'h5A5A, 1'b1}) begin errs++; $display("FAIL dbl_word: got %h want %h", {rx_data_o, trx_if.rx_clk_reset}, {16'h5A5A, 1'b1}); end
        step();
        trx_if.rx_valid = 1'b0;
        close_txn(h, d, e, r, n);
        vecs++; if ({d, e} !== 2'b10) begin errs++; $display("FAIL dbl_done: got %b want 10", {d, e}); end
        // Fixed latency with RWDS low, burst 0 taken as a single word.
        cfg_fixed_lat_i = 1'b1;
        send_req(1'b0, 1'b0, 32'h0000_0040, 16'd0, 2'b01);
        to_latency();
        count_read_latency(1'b0, n);
        vecs++; if (n !== 10) begin errs++; $display("FAIL fixed_latency: got %0d want 10", n); end
        trx_if.rx_valid = 1'b1; trx_if.rx_data = 16'h0BAD;
        #1;
        vecs++; if (trx_if.rx_clk_reset !== 1'b1) begin errs++; $display("FAIL burst0_last: got %b want 1", trx_if.rx_clk_reset); end
        step();
        trx_if.rx_valid = 1'b0;
        close_txn(h, d, e, r, n);
        vecs++; if ({h, d, e, r} !== 4'b1101) begin errs++; $display("FAIL fixed_close: got %b want 1101", {h, d, e, r}); end
        cfg_fixed_lat_i = 1'b0;
    endtask

    task automatic test_reg_write();
        logic [15:0] exp_ca [3];
        logic        h, d, e, r;
        int          n;
        exp_ca[0] = 16'h6000; exp_ca[1] = 16'h0100; exp_ca[2] = 16'h0000;
        send_req(1'b1, 1'b1, 32'h0000_0800, 16'd1, 2'b01);
        trx_if.rwds_sample = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            vecs++; if (trx_if.tx_data !== exp_ca[i]) begin errs++; $display("FAIL reg_ca%0d: got %h want %h", i, trx_if.tx_data, exp_ca[i]); end
        end
        step();
        tx_valid_i = 1'b1; tx_data_i = 16'h8F1F; tx_strb_i = 2'b11;
        #1;
        vecs++; if ({tx_ready_o, trx_if.tx_data_oe, trx_if.tx_clk_ena, trx_if.tx_rwds_oe, trx_if.tx_data} !== {4'b1110, 16'h8F1F}) begin errs++; $display("FAIL reg_data: got %h want %h", {tx_ready_o, trx_if.tx_data_oe, trx_if.tx_clk_ena, trx_if.tx_rwds_oe, trx_if.tx_data}, {4'b1110, 16'h8F1F}); end
        step();
        tx_valid_i = 1'b0;
        trx_if.rwds_sample = 1'b0;
        close_txn(h, d, e, r, n);
        vecs++; if ({h, d, e, r} !== 4'b1101) begin errs++; $display("FAIL reg_close: got %b want 1101", {h, d, e, r}); end
    endtask

    task automatic test_mem_write();
        logic h, d, e, r;
        int   n;
        cfg_latency_i = 4'd1;
        send_req(1'b1, 1'b0, 32'h0000_0100, 16'd3, 2'b01);
        to_latency();
        #1;
        n = 0;
        while (trx_if.tx_clk_ena && !trx_if.tx_data_oe && n < 40) begin
            n++;
            step();
            #1;
        end
        vecs++; if (n !== 2) begin errs++; $display("FAIL wr_latency_clamp: got %0d want 2", n); end
        vecs++; if ({tx_ready_o, trx_if.tx_clk_ena} !== 2'b10) begin errs++; $display("FAIL wr_idle_ck: got %b want 10", {tx_ready_o, trx_if.tx_clk_ena}); end
        tx_valid_i = 1'b1; tx_data_i = 16'h1111; tx_strb_i = 2'b11;
        #1;
        vecs++; if ({trx_if.tx_data_oe, trx_if.tx_rwds_oe, trx_if.tx_rwds, trx_if.tx_data} !== {4'b1100, 16'h1111}) begin errs++; $display("FAIL wr_word0: got %h want %h", {trx_if.tx_data_oe, trx_if.tx_rwds_oe, trx_if.tx_rwds, trx_if.tx_data}, {4'b1100, 16'h1111}); end
        for (int i = 0; i < 2; i++) begin
            step();
            tx_valid_i = 1'b0;
            #1;
            vecs++; if ({tx_ready_o, trx_if.tx_clk_ena, trx_if.tx_data_oe} !== 3'b100) begin errs++; $display("FAIL wr_gap%0d: got %b want 100", i, {tx_ready_o, trx_if.tx_clk_ena, trx_if.tx_data_oe}); end
        end
        step();
        tx_valid_i = 1'b1; tx_data_i = 16'h2222;
        #1;
        vecs++; if ({trx_if.tx_clk_ena, trx_if.tx_data} !== {1'b1, 16'h2222}) begin errs++; $display("FAIL wr_word1: got %h want %h", {trx_if.tx_clk_ena, trx_if.tx_data}, {1'b1, 16'h2222}); end
        step();
        tx_data_i = 16'h3333; tx_strb_i = 2'b01;
        #1;
        vecs++; if ({tx_ready_o, trx_if.tx_rwds_oe, trx_if.tx_rwds} !== 4'b1110) begin errs++; $display("FAIL wr_strb: got %b want 1110", {tx_ready_o, trx_if.tx_rwds_oe, trx_if.tx_rwds}); end
        step();
        #1;
        vecs++; if ({tx_ready_o, trx_if.tx_data_oe} !== 2'b00) begin errs++; $display("FAIL wr_count: got %b want 00", {tx_ready_o, trx_if.tx_data_oe}); end
        tx_valid_i = 1'b0;
        close_txn(h, d, e, r, n);
        vecs++; if ({h, d, e, r} !== 4'b1101) begin errs++; $display("FAIL wr_close: got %b want 1101", {h, d, e, r}); end
        cfg_latency_i = 4'd6;
    endtask

    // Leaves a second read running so the next task can reset it mid-flight.
    task automatic test_timeout_and_hold();
        logic h, d, e, r;
        int   n, m;
        trx_if.rx_valid = 1'b0;
        rx_ready_i = 1'b1;
        send_req(1'b0, 1'b0, 32'h0000_0010, 16'd2, 2'b01);
        to_latency();
        count_read_latency(1'b0, n);
        #1;
        m = 1;
        while (!trx_if.rx_clk_reset && m < 40) begin
            step();
            #1;
            m++;
        end
        vecs++; if (m !== 16) begin errs++; $display("FAIL to_cycles: got %0d want 16", m); end
        vecs++; if (rx_valid_o !== 1'b0) begin errs++; $display("FAIL to_rx_valid: got %b want 0", rx_valid_o); end
        trans_valid_i = 1'b1; trans_write_i = 1'b0; trans_reg_i = 1'b0;
        trans_addr_i = 32'h0000_2000; trans_burst_i = 16'd1; trans_cs_i = 2'b10;
        step();
        close_txn(h, d, e, r, n);
        vecs++; if ({h, d, e, r} !== 4'b1111) begin errs++; $display("FAIL to_close: got %b want 1111", {h, d, e, r}); end
        vecs++; if (n !== 2) begin errs++; $display("FAIL to_recovery: got %0d want 2", n); end
        step();
        trans_valid_i = 1'b0;
        #1;
        vecs++; if ({trx_if.cs_ena, trx_if.cs, trans_ready_o} !== 4'b1100) begin errs++; $display("FAIL held_req: got %b want 1100", {trx_if.cs_ena, trx_if.cs, trans_ready_o}); end
    endtask

    task automatic test_reset_mid_read();
        logic seen;
        int   n;
        to_latency();
        count_read_latency(1'b0, n);
        #1;
        rst_ni = 1'b0;
        #1;
        vecs++; if ({trx_if.cs_ena, trx_if.cs, trx_if.tx_clk_ena, trans_ready_o} !== 5'b00001) begin errs++; $display("FAIL rst_abort: got %b want 00001", {trx_if.cs_ena, trx_if.cs, trx_if.tx_clk_ena, trans_ready_o}); end
        step();
        rst_ni = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            step();
            #1;
            seen = seen | trans_done_o;
        end
        vecs++; if ({seen, trans_ready_o} !== 2'b01) begin errs++; $display("FAIL rst_no_done: got %b want 01", {seen, trans_ready_o}); end
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_double_latency();
        test_reg_write();
        test_mem_write();
        test_timeout_and_hold();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
